// File: rtl/imm_pkg.sv
// imm_pkg: shared format codes, opcodes and buffer entry layout for imm_gen_stage.
`default_nettype none

package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_REG_32 = 7'b0111011;

    // Entry fields are sized for the widest supported configuration (XLEN and TAG_W up to 64).
    typedef struct packed {
        logic [63:0] imm;
        fmt_t        fmt;
        logic        illegal;
        logic [63:0] tag;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{imm: 64'd0, fmt: FMT_NONE, illegal: 1'b0, tag: 64'd0};

endpackage

`default_nettype wire

// File: rtl/imm_decode.sv
// ---------------------------------------------------------------------------
// imm_decode : combinational RV32I/RV64I format classifier and immediate builder
// Rev 1.0    : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_t            fmt,
    output logic            illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic signed [31:0] imm32;
    logic              is_shift;
    logic [5:0]        shamt;

    always_comb begin
        opcode   = inst[6:0];
        funct3   = inst[14:12];
        fmt      = FMT_NONE;
        is_shift = 1'b0;
        shamt    = {1'b0, inst[24:20]};
        imm32    = '0;

        case (opcode)
            OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: fmt = FMT_I;
            OP_IMM: begin
                fmt      = FMT_I;
                is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
                if (RV64) shamt = inst[25:20];
            end
            OP_STORE:          fmt = FMT_S;
            OP_BRANCH:         fmt = FMT_B;
            OP_LUI, OP_AUIPC:  fmt = FMT_U;
            OP_JAL:            fmt = FMT_J;
            OP_REG:            fmt = FMT_R;
            OP_IMM_32: begin
                if (RV64) begin
                    fmt      = FMT_I;
                    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
                end
            end
            OP_REG_32: begin
                if (RV64) fmt = FMT_R;
            end
            default: fmt = FMT_NONE;
        endcase

        illegal = (fmt == FMT_NONE);

        case (fmt)
            FMT_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U: imm32 = {inst[31:12], 12'h000};
            FMT_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase

        // Signed cast widens imm32 by replicating inst[31]; shamt is zero-extended.
        if (is_shift) imm = XLEN'(shamt);
        else          imm = XLEN'(imm32);
    end

endmodule

`default_nettype wire

// File: rtl/imm_gen_stage.sv
// ---------------------------------------------------------------------------
// imm_gen_stage : decode-stage immediate generator behind a 2-entry skid buffer
// Rev 1.0       : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0] dec_imm;
    fmt_t            dec_fmt;
    logic            dec_illegal;

    entry_t     mem [2];
    entry_t     new_entry;
    entry_t     head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic       unused_bits;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    // in_ready depends only on stored count and flush, never on out_ready.
    assign in_ready  = (count < 2'd2) && !flush;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        new_entry                  = '0;
        new_entry.imm[XLEN-1:0]    = dec_imm;
        new_entry.fmt              = dec_fmt;
        new_entry.illegal          = dec_illegal;
        new_entry.tag[TAG_W-1:0]   = in_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= ENTRY_RESET;
            mem[1] <= ENTRY_RESET;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head        = mem[rd_ptr];
    assign out_imm     = head.imm[XLEN-1:0];
    assign out_fmt     = head.fmt;
    assign out_illegal = head.illegal;
    assign out_tag     = head.tag[TAG_W-1:0];
    assign unused_bits = ^{head.imm, head.tag};

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: XLEN=32 and XLEN=64 instances with directed vectors.
`default_nettype none

module tb_imm_gen_stage;
    import imm_pkg::*;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   checks = 0;
    int   errors = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_inst, in_tag, out_tag, out_imm;
    logic [2:0]  out_fmt;

    logic        d64_flush, d64_in_valid, d64_in_ready, d64_out_valid, d64_out_ready, d64_out_illegal;
    logic [31:0] d64_in_inst, d64_in_tag, d64_out_tag;
    logic [63:0] d64_out_imm;
    logic [2:0]  d64_out_fmt;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(d64_flush),
        .in_valid(d64_in_valid), .in_ready(d64_in_ready), .in_inst(d64_in_inst), .in_tag(d64_in_tag),
        .out_valid(d64_out_valid), .out_ready(d64_out_ready), .out_imm(d64_out_imm),
        .out_fmt(d64_out_fmt), .out_illegal(d64_out_illegal), .out_tag(d64_out_tag)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors sample 2 time units after the falling edge, when all inputs have settled.
    always @(negedge clk) begin : mon32
        exp_t e;
        #2;
        if (rst_n && out_valid && out_ready && !flush) begin
            if (q32.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected32: got beat tag %0d, expected none", out_tag);
            end else begin
                e = q32.pop_front();
                chk("imm32", {32'd0, out_imm}, e.imm);
                chk("fmt32", {61'd0, out_fmt}, {61'd0, e.fmt});
                chk("ill32", {63'd0, out_illegal}, {63'd0, e.ill});
                chk("tag32", {32'd0, out_tag}, {32'd0, e.tag});
            end
        end
    end

    always @(negedge clk) begin : mon64
        exp_t e;
        #2;
        if (rst_n && d64_out_valid && d64_out_ready && !d64_flush) begin
            if (q64.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected64: got beat tag %0d, expected none", d64_out_tag);
            end else begin
                e = q64.pop_front();
                chk("imm64", d64_out_imm, e.imm);
                chk("fmt64", {61'd0, d64_out_fmt}, {61'd0, e.fmt});
                chk("ill64", {63'd0, d64_out_illegal}, {63'd0, e.ill});
                chk("tag64", {32'd0, d64_out_tag}, {32'd0, e.tag});
            end
        end
    end

    task automatic push32(input logic [31:0] inst, input logic [31:0] tag,
                          input logic [63:0] eimm, input logic [2:0] efmt, input logic eill);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1; in_inst = inst; in_tag = tag;
        #1;
        while (!in_ready && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        if (in_ready) q32.push_back('{eimm, efmt, eill, tag});
        else begin
            checks++; errors++;
            $display("FAIL push32_timeout: tag %0d never accepted, expected acceptance", tag);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic push64(input logic [31:0] inst, input logic [31:0] tag,
                          input logic [63:0] eimm, input logic [2:0] efmt, input logic eill);
        int waited = 0;
        @(negedge clk);
        d64_in_valid = 1'b1; d64_in_inst = inst; d64_in_tag = tag;
        #1;
        while (!d64_in_ready && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        if (d64_in_ready) q64.push_back('{eimm, efmt, eill, tag});
        else begin
            checks++; errors++;
            $display("FAIL push64_timeout: tag %0d never accepted, expected acceptance", tag);
        end
        @(posedge clk); #1;
        d64_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 50) begin
            @(negedge clk); n++;
        end
        checks++;
        if (q32.size() != 0 || q64.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d beats outstanding, expected 0/0", q32.size(), q64.size());
        end
    endtask

    logic [31:0] t32_inst [9] = '{32'hFE000EE3, 32'h0010006F, 32'hFE21AC23, 32'h4030D093,
                                 32'hFFF00093, 32'h12345037, 32'h00208033, 32'h0000001B, 32'h0000007F};
    logic [63:0] t32_imm  [9] = '{64'hFFFFFFFC, 64'h00000800, 64'hFFFFFFF8, 64'h00000003,
                                 64'hFFFFFFFF, 64'h12345000, 64'h0, 64'h0, 64'h0};
    logic [2:0]  t32_fmt  [9] = '{3'd3, 3'd5, 3'd2, 3'd1, 3'd1, 3'd4, 3'd0, 3'd7, 3'd7};
    logic        t32_ill  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    logic [31:0] t64_inst [6] = '{32'h800000B7, 32'h00000000, 32'h4250D093,
                                 32'hFFF0809B, 32'h0000003B, 32'hFE000EE3};
    logic [63:0] t64_imm  [6] = '{64'hFFFFFFFF80000000, 64'h0, 64'h25,
                                 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFC};
    logic [2:0]  t64_fmt  [6] = '{3'd4, 3'd7, 3'd1, 3'd1, 3'd0, 3'd3};
    logic        t64_ill  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b1;
        d64_flush = 1'b0; d64_in_valid = 1'b0; d64_in_inst = '0; d64_in_tag = '0; d64_out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_imm", {32'd0, out_imm}, 64'd0);
        chk("rst_out_fmt", {61'd0, out_fmt}, 64'd7);
        chk("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
        chk("rst_out_tag", {32'd0, out_tag}, 64'd0);
        chk("rst64_out_imm", d64_out_imm, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);

        for (int i = 0; i < 9; i++) push32(t32_inst[i], 32'(i + 100), t32_imm[i], t32_fmt[i], t32_ill[i]);
        for (int i = 0; i < 6; i++) push64(t64_inst[i], 32'(i + 200), t64_imm[i], t64_fmt[i], t64_ill[i]);
        drain();

        // Back-pressure: two beats absorbed, third held off until the consumer drains.
        @(negedge clk);
        out_ready = 1'b0;
        push32(32'hFFF00093, 32'd1, 64'hFFFFFFFF, 3'd1, 1'b0);
        push32(32'h00100093, 32'd2, 64'h00000001, 3'd1, 1'b0);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h00200093; in_tag = 32'd3;
        #1;
        chk("bp_beat3_refused", {63'd0, in_ready}, 64'd0);
        repeat (2) begin
            @(negedge clk); #1;
            chk("bp_head_stable_tag", {32'd0, out_tag}, 64'd1);
            chk("bp_head_stable_imm", {32'd0, out_imm}, 64'hFFFFFFFF);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        push32(32'h00200093, 32'd3, 64'h00000002, 3'd1, 1'b0);
        drain();

        // Flush with two entries held and a beat offered in the flush cycle.
        @(negedge clk);
        out_ready = 1'b0;
        push32(32'h00A00093, 32'd10, 64'h0A, 3'd1, 1'b0);
        push32(32'h00B00093, 32'd11, 64'h0B, 3'd1, 1'b0);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00C00093; in_tag = 32'd12;
        q32.delete();
        #1;
        chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready_after", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        push32(32'h00D00093, 32'd13, 64'h0D, 3'd1, 1'b0);
        drain();

        // Asynchronous reset in the middle of a cycle with two entries held.
        @(negedge clk);
        out_ready = 1'b0;
        push32(32'h01400093, 32'd20, 64'h14, 3'd1, 1'b0);
        push32(32'h01500093, 32'd21, 64'h15, 3'd1, 1'b0);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_out_tag", {32'd0, out_tag}, 64'd0);
        q32.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_release_out_valid", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        push32(32'h01600093, 32'd22, 64'h16, 3'd1, 1'b0);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
